// File: rtl/cmd_ingress_queue.sv
// Multi-channel command ingress: round-robin arbitration into a first-word-fall-through FIFO,
// with in-flight tracking that drives a registered all-done flag and a busy-cycle counter.
module cmd_ingress_queue #(
    parameter int CH    = 4,
    parameter int DEPTH = 8,
    parameter int CMD_W = 64,
    parameter int CNT_W = 32,
    parameter int OUT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [CH-1:0]            i_push,
    input  logic [CH*CMD_W-1:0]      i_cmd,
    output logic [CH-1:0]            o_grant,
    input  logic                     i_rd,
    output logic [CMD_W-1:0]         o_cmd,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_flush,
    input  logic                     i_finished_task,
    output logic                     o_all_done,
    output logic [CNT_W-1:0]         o_busy_cycles,
    output logic [1:0]               o_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (CH > 1) ? $clog2(CH) : 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [RW-1:0]    rr_ptr, win, idx;
    logic             found, grant_ok, push, pop;
    logic [CW-1:0]    count_nx;
    logic [OUT_W-1:0] inflight, inflight_nx;
    logic [CMD_W-1:0] wdata;

    // Search starts one past the last winner so every requester is served within CH grants.
    always_comb begin
        found    = 1'b0;
        win      = rr_ptr;
        idx      = '0;
        o_grant  = '0;
        grant_ok = !i_flush && (!o_full || i_rd);
        for (int k = 1; k <= CH; k++) begin
            idx = RW'((int'(rr_ptr) + k) % CH);
            if (!found && i_push[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (grant_ok && found) o_grant[win] = 1'b1;
    end

    assign push     = |o_grant;
    assign pop      = i_rd && !o_empty && !i_flush;
    assign count_nx = i_flush ? '0 : o_count + CW'(push) - CW'(pop);
    assign wdata    = i_cmd[win*CMD_W +: CMD_W];
    assign o_cmd    = mem[rd_ptr];

    always_comb begin
        inflight_nx = inflight;
        if (pop && !i_finished_task) begin
            if (inflight != '1) inflight_nx = inflight + 1'b1;
        end else if (!pop && i_finished_task && inflight != '0) begin
            inflight_nx = inflight - 1'b1;
        end
    end

    // Storage is reset so the head reads zero out of reset; when full, a concurrent
    // push overwrites the slot being popped at the same edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_count       <= '0;
            o_empty       <= 1'b1;
            o_full        <= 1'b0;
            rr_ptr        <= RW'(CH - 1);
            inflight      <= '0;
            o_all_done    <= 1'b1;
            o_busy_cycles <= '0;
            o_err         <= '0;
        end else begin
            wr_ptr     <= i_flush ? '0 : wr_ptr + PW'(push);
            rd_ptr     <= i_flush ? '0 : rd_ptr + PW'(pop);
            o_count    <= count_nx;
            o_empty    <= (count_nx == '0);
            o_full     <= (count_nx == CW'(DEPTH));
            inflight   <= inflight_nx;
            o_all_done <= (count_nx == '0) && (inflight_nx == '0) && (i_push == '0);
            if (push) rr_ptr <= win;
            if (!o_all_done && o_busy_cycles != '1) o_busy_cycles <= o_busy_cycles + 1'b1;
            if (i_rd && o_empty && !i_flush) o_err[0] <= 1'b1;
            if (i_finished_task && !pop && inflight == '0) o_err[1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cmd_ingress_queue.sv
// Bench for cmd_ingress_queue: vector table plus hand sequences; a command scoreboard
// tracks the expected FIFO contents from the grants the bench expects.
module tb_cmd_ingress_queue;
    localparam int CH = 4, DEPTH = 8, CMD_W = 16, CNT_W = 32, OUT_W = 8;

    logic                   i_clk = 1'b0;
    logic                   i_rstn = 1'b0;
    logic [CH-1:0]          i_push = '0;
    logic [CH*CMD_W-1:0]    i_cmd;
    logic [CH-1:0]          o_grant;
    logic                   i_rd = 1'b0;
    logic [CMD_W-1:0]       o_cmd;
    logic                   o_empty, o_full;
    logic [$clog2(DEPTH):0] o_count;
    logic                   i_flush = 1'b0;
    logic                   i_finished_task = 1'b0;
    logic                   o_all_done;
    logic [CNT_W-1:0]       o_busy_cycles;
    logic [1:0]             o_err;

    logic [CMD_W-1:0] cmd_v [CH];
    logic [CMD_W-1:0] sb [$];
    int total = 0;
    int bad = 0;

    assign i_cmd = {cmd_v[3], cmd_v[2], cmd_v[1], cmd_v[0]};

    cmd_ingress_queue #(.CH(CH), .DEPTH(DEPTH), .CMD_W(CMD_W), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_push(i_push), .i_cmd(i_cmd), .o_grant(o_grant),
        .i_rd(i_rd), .o_cmd(o_cmd), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
        .i_flush(i_flush), .i_finished_task(i_finished_task), .o_all_done(o_all_done),
        .o_busy_cycles(o_busy_cycles), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0] push;
        logic       rd, fl, fin;
        logic [3:0] grant;
        int         done;
    } vec_t;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    task automatic do_reset();
        i_rstn = 1'b0;
        i_push = '0; i_rd = 1'b0; i_flush = 1'b0; i_finished_task = 1'b0;
        for (int c = 0; c < CH; c++) cmd_v[c] = CMD_W'(16'h1000 * (c + 1));
        sb.delete();
        @(posedge i_clk);
        @(posedge i_clk);
        #3 i_rstn = 1'b1;
    endtask

    // One clock: drive, check grant, advance, update the scoreboard, check registered outputs.
    task automatic cyc(input logic [3:0] p, input logic rd, input logic fl, input logic fin,
                       input logic [3:0] g, input int done);
        logic do_pop;
        int gc;
        i_push = p; i_rd = rd; i_flush = fl; i_finished_task = fin;
        #1 chk("grant", o_grant, g);
        do_pop = rd && !fl && sb.size() > 0;
        gc = -1;
        for (int c = 0; c < CH; c++) if (g[c]) gc = c;
        @(posedge i_clk);
        #1;
        if (do_pop) void'(sb.pop_front());
        if (fl) sb.delete();
        if (gc >= 0) begin
            sb.push_back(cmd_v[gc]);
            cmd_v[gc] = cmd_v[gc] + 1'b1;
        end
        chk("count", o_count, 64'(sb.size()));
        chk("empty", o_empty, sb.size() == 0);
        chk("full", o_full, sb.size() == DEPTH);
        if (sb.size() > 0) chk("head", o_cmd, sb[0]);
        if (done >= 0) chk("all_done", o_all_done, done[0]);
    endtask

    vec_t tbl [14];

    initial begin
        // push/pop/finish sequence covering latency, in-flight and all-done
        tbl[0]  = '{4'b0001, 0, 0, 0, 4'b0001, 0};
        tbl[1]  = '{4'b0001, 0, 0, 0, 4'b0001, 0};
        tbl[2]  = '{4'b0001, 0, 0, 0, 4'b0001, 0};
        tbl[3]  = '{4'b0000, 1, 0, 0, 4'b0000, 0};
        tbl[4]  = '{4'b0000, 1, 0, 0, 4'b0000, 0};
        tbl[5]  = '{4'b0000, 1, 0, 0, 4'b0000, 0};
        tbl[6]  = '{4'b0000, 0, 0, 1, 4'b0000, 0};
        tbl[7]  = '{4'b0000, 0, 0, 1, 4'b0000, 0};
        tbl[8]  = '{4'b0000, 0, 0, 1, 4'b0000, 1};
        tbl[9]  = '{4'b0010, 0, 0, 0, 4'b0010, 0};
        tbl[10] = '{4'b0000, 1, 0, 0, 4'b0000, 0};
        tbl[11] = '{4'b0100, 0, 0, 0, 4'b0100, 0};
        tbl[12] = '{4'b0000, 1, 0, 1, 4'b0000, 0};
        tbl[13] = '{4'b0000, 0, 0, 1, 4'b0000, 1};

        do_reset();
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_cmd", o_cmd, 0);
        chk("rst_done", o_all_done, 1);
        chk("rst_busy", o_busy_cycles, 0);
        chk("rst_err", o_err, 0);
        cyc(4'b0, 0, 0, 0, 4'b0, 1);
        cyc(4'b0, 0, 0, 0, 4'b0, 1);
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].push, tbl[i].rd, tbl[i].fl, tbl[i].fin, tbl[i].grant, tbl[i].done);
            if (i == 8) chk("busy_a", o_busy_cycles, 8);
        end
        for (int i = 0; i < 3; i++) cyc(4'b0, 0, 0, 0, 4'b0, 1);
        chk("busy_frozen", o_busy_cycles, 12);
        chk("err_clean", o_err, 0);

        // all channels pushing: rotation from channel 0, then stall when full
        do_reset();
        for (int i = 0; i < 8; i++) cyc(4'hF, 0, 0, 0, 4'(4'b0001 << (i % 4)), 0);
        cyc(4'hF, 0, 0, 0, 4'b0, 0);
        cyc(4'hF, 0, 0, 0, 4'b0, 0);
        // full with pop: ch2 granted in the same cycle, then drain to its command
        cyc(4'b0100, 1, 0, 0, 4'b0100, 0);
        for (int i = 0; i < 8; i++) cyc(4'b0, 1, 0, 0, 4'b0, -1);

        // error flags are sticky until reset
        do_reset();
        cyc(4'b0, 1, 0, 0, 4'b0, 1);
        chk("err_pop_empty", o_err, 2'b01);
        chk("cmd_after_bad_pop", o_cmd, 0);
        cyc(4'b0, 0, 0, 1, 4'b0, 1);
        chk("err_fin", o_err, 2'b11);
        for (int i = 0; i < 3; i++) cyc(4'b0, 0, 0, 0, 4'b0, 1);
        chk("err_sticky", o_err, 2'b11);
        do_reset();
        chk("err_cleared", o_err, 0);

        // flush at count 5 with one command in flight
        for (int i = 0; i < 6; i++) cyc(4'b0001, 0, 0, 0, 4'b0001, 0);
        cyc(4'b0, 1, 0, 0, 4'b0, 0);
        chk("pre_flush_count", o_count, 5);
        cyc(4'b0010, 1, 1, 0, 4'b0, 0);
        cyc(4'b0, 0, 0, 0, 4'b0, 0);
        cyc(4'b0, 0, 0, 1, 4'b0, 1);
        chk("flush_err", o_err, 0);

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) cyc(4'b0001, 0, 0, 0, 4'b0001, 0);
        i_push = '0;
        #2 i_rstn = 1'b0;
        #1;
        chk("arst_count", o_count, 0);
        chk("arst_empty", o_empty, 1);
        chk("arst_full", o_full, 0);
        chk("arst_cmd", o_cmd, 0);
        chk("arst_done", o_all_done, 1);
        chk("arst_busy", o_busy_cycles, 0);
        chk("arst_err", o_err, 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
